// File: rtl/pikachu_pkg.sv
// Shared geometry, colour indices and helpers for the Pikachu sprite path.
package pikachu_pkg;

  localparam int SPR_W      = 32;
  localparam int SPR_H      = 32;
  localparam int SCALE_LOG2 = 2;
  localparam int H_ACT      = 640;
  localparam int V_ACT      = 480;
  localparam int ROM_AW     = 11;

  localparam logic [2:0] BG     = 3'd0;
  localparam logic [2:0] BLACK  = 3'd1;
  localparam logic [2:0] YELLOW = 3'd2;
  localparam logic [2:0] RED    = 3'd3;
  localparam logic [2:0] WHITE  = 3'd4;
  localparam logic [2:0] BROWN  = 3'd5;

  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/pikachu_anim_timer.sv
// Counts frame_start pulses and flips the animation frame select every
// ANIM_FRAMES video frames.
module pikachu_anim_timer #(
  parameter int ANIM_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start_i,
  output logic anim_sel_o
);

  localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ANIM_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             anim_q, anim_d;
  logic             wrap;

  always_comb begin
    wrap   = frame_start_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    anim_d = anim_q ^ wrap;
    if (frame_start_i) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      anim_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      anim_q <= anim_d;
    end
  end

  assign anim_sel_o = anim_q;

endmodule

// File: rtl/pikachu_sprite_fetch.sv
// Sprite hit test, ROM address generation and the 2-clock colour pipeline
// feeding the palette decoder.
module pikachu_sprite_fetch
  import pikachu_pkg::*;
#(
  parameter int ANIM_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_valid,
  input  logic              frame_start,
  input  logic [9:0]        req_x,
  input  logic [9:0]        req_y,
  input  logic              req_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic [2:0]        color,
  output logic              color_valid
);

  localparam int          TX_W   = $clog2(SPR_W);
  localparam int          TY_W   = $clog2(SPR_H);
  localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_LOG2);
  localparam logic [9:0]  MAX_X  = 10'(H_ACT - (SPR_W << SCALE_LOG2));
  localparam logic [9:0]  MAX_Y  = 10'(V_ACT - (SPR_H << SCALE_LOG2));

  logic [9:0]        cur_x_q, cur_x_d;
  logic [9:0]        cur_y_q, cur_y_d;
  logic              cur_en_q, cur_en_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              v1_q, h1_q, v2_q, h2_q;
  logic [2:0]        color_q, color_d;
  logic              color_valid_q;

  logic              anim_sel;
  logic [10:0]       px, py, cx, cy, dx, dy;
  logic              hit_x, hit_y, hit;

  pikachu_anim_timer #(
    .ANIM_FRAMES(ANIM_FRAMES)
  ) u_anim (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start_i(frame_start),
    .anim_sel_o   (anim_sel)
  );

  // Position only moves at frame_start, so a pixel coinciding with the pulse
  // still sees the old position.
  always_comb begin
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    cur_en_d = cur_en_q;
    if (frame_start) begin
      cur_x_d  = clamp10(req_x, MAX_X);
      cur_y_d  = clamp10(req_y, MAX_Y);
      cur_en_d = req_en;
    end
  end

  // 11-bit arithmetic keeps cur + span from wrapping at the screen edge.
  always_comb begin
    px    = {1'b0, pix_x};
    py    = {1'b0, pix_y};
    cx    = {1'b0, cur_x_q};
    cy    = {1'b0, cur_y_q};
    dx    = px - cx;
    dy    = py - cy;
    hit_x = (px >= cx) && (px < cx + SPAN_X);
    hit_y = (py >= cy) && (py < cy + SPAN_Y);
    hit   = pix_valid && cur_en_q && hit_x && hit_y;
    rom_addr_d = rom_addr_q;
    if (hit) begin
      rom_addr_d = {anim_sel, TY_W'(dy >> SCALE_LOG2), TX_W'(dx >> SCALE_LOG2)};
    end
  end

  always_comb begin
    color_d = h2_q ? rom_data : BG;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      cur_en_q      <= 1'b0;
      rom_addr_q    <= '0;
      v1_q          <= 1'b0;
      h1_q          <= 1'b0;
      v2_q          <= 1'b0;
      h2_q          <= 1'b0;
      color_q       <= BG;
      color_valid_q <= 1'b0;
    end else begin
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      cur_en_q      <= cur_en_d;
      rom_addr_q    <= rom_addr_d;
      v1_q          <= pix_valid;
      h1_q          <= hit;
      v2_q          <= v1_q;
      h2_q          <= h1_q;
      color_q       <= color_d;
      color_valid_q <= v2_q;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign color       = color_q;
  assign color_valid = color_valid_q;

endmodule

// File: tb/tb_pikachu_sprite_fetch.sv
// Directed bench for pikachu_sprite_fetch with a synchronous ROM model and
// an expected-output queue two pixels deep.
module tb_pikachu_sprite_fetch;

  logic        clk = 1'b0;
  logic        rst_n, frame_start, pix_valid, req_en;
  logic [9:0]  pix_x, pix_y, req_x, req_y;
  logic [10:0] rom_addr;
  logic [2:0]  rom_data, color;
  logic        color_valid;

  always #5 clk = ~clk;

  pikachu_sprite_fetch #(
    .ANIM_FRAMES(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_en     (req_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .color      (color),
    .color_valid(color_valid)
  );

  function automatic logic [2:0] rom_fn(input logic [10:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ {a[10:9], 1'b0};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // reference model state
  int          m_cx, m_cy, m_cnt;
  logic        m_en, m_anim;
  logic [10:0] m_addr;
  logic [3:0]  exp_q[$];
  int          n_checks = 0;
  int          n_bad    = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic fs, input logic pv, input int x, input int y);
    logic       hit;
    logic [3:0] e;
    int         tx, ty;
    rst_n       = ~rst;
    frame_start = fs;
    pix_valid   = pv;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    if (rst) begin
      m_cx = 0; m_cy = 0; m_cnt = 0; m_en = 1'b0; m_anim = 1'b0; m_addr = '0;
    end else begin
      hit = pv && m_en && (x >= m_cx) && (x < m_cx + 128) && (y >= m_cy) && (y < m_cy + 128);
      if (hit) begin
        tx = (x - m_cx) / 4;
        ty = (y - m_cy) / 4;
        m_addr = {m_anim, 5'(ty), 5'(tx)};
      end
      exp_q.push_back({pv, hit ? rom_fn(m_addr) : 3'd0});
      if (fs) begin
        m_cx = (int'(req_x) > 512) ? 512 : int'(req_x);
        m_cy = (int'(req_y) > 352) ? 352 : int'(req_y);
        m_en = req_en;
        if (m_cnt == 2) begin
          m_cnt  = 0;
          m_anim = ~m_anim;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      check("rst_color", 16'(color), 16'd0);
      check("rst_valid", 16'(color_valid), 16'd0);
      check("rst_addr", 16'(rom_addr), 16'd0);
      exp_q.delete();
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd0);
    end else begin
      e = exp_q.pop_front();
      check("color", 16'(color), 16'(e[2:0]));
      check("valid", 16'(color_valid), 16'(e[3]));
      check("addr", 16'(rom_addr), 16'(m_addr));
    end
  endtask

  initial begin
    req_x = '0; req_y = '0; req_en = 1'b0;
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;

    // reset held with a live pixel stream and a frame_start that must be ignored
    for (int i = 0; i < 4; i++) step(1'b1, i == 1, 1'b1, i, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 10 + i, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);

    // sprite at (100,50), scan line 50 across both edges
    req_x = 10'd100; req_y = 10'd50; req_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 0, 0);
    for (int x = 96; x <= 232; x++) begin
      step(1'b0, 1'b0, 1'b1, x, 50);
      if (x == 100) check("x100_addr", 16'(rom_addr), 16'h000);
      if (x == 103) check("x103_addr", 16'(rom_addr), 16'h000);
      if (x == 104) check("x104_addr", 16'(rom_addr), 16'h001);
      if (x == 227) check("x227_addr", 16'(rom_addr), 16'h01F);
      if (x == 228) check("x228_hold", 16'(rom_addr), 16'h01F);
    end
    step(1'b0, 1'b0, 1'b1, 110, 54);
    check("y54_addr", 16'(rom_addr), 16'h022);

    // request moves mid-frame: no effect until the next frame_start
    req_x = 10'd300; req_y = 10'd200;
    step(1'b0, 1'b0, 1'b1, 120, 50);
    check("old_pos_hit", 16'(rom_addr), 16'h005);
    step(1'b0, 1'b0, 1'b1, 300, 200);
    check("midframe_hold", 16'(rom_addr), 16'h005);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 300, 200);
    check("new_pos_hit", 16'(rom_addr), 16'h000);
    step(1'b0, 1'b0, 1'b1, 299, 200);
    step(1'b0, 1'b0, 1'b1, 100, 50);

    // clamp to (512,352); third pulse flips the animation frame
    req_x = 10'd600; req_y = 10'd470;
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 639, 479);
    check("corner_addr", 16'(rom_addr), 16'h7FF);
    step(1'b0, 1'b0, 1'b1, 511, 351);
    step(1'b0, 1'b0, 1'b1, 512, 352);
    check("clamp_origin", 16'(rom_addr), 16'h400);

    for (int p = 4; p <= 6; p++) begin
      step(1'b0, 1'b1, 1'b0, 0, 0);
      step(1'b0, 1'b0, 1'b1, 512, 352);
      check("anim_sel", 16'(rom_addr[10]), (p == 6) ? 16'd0 : 16'd1);
    end

    // frame_start coincident with a valid pixel uses the old position
    req_x = 10'd0; req_y = 10'd0; req_en = 1'b1;
    step(1'b0, 1'b1, 1'b1, 512, 352);
    check("coinc_old", 16'(rom_addr), 16'h000);
    step(1'b0, 1'b0, 1'b1, 512, 352);
    step(1'b0, 1'b0, 1'b1, 127, 127);
    check("new_corner", 16'(rom_addr), 16'h3FF);
    step(1'b0, 1'b0, 1'b1, 128, 0);

    // sprite disabled: colour stays background, valid still tracks
    req_en = 1'b0;
    step(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, (i % 3) != 0, i, i);

    // reset in the middle of a line of hits discards in-flight pixels
    req_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, i * 4, 8);
    step(1'b1, 1'b0, 1'b1, 16, 8);
    step(1'b1, 1'b0, 1'b1, 20, 8);
    for (int i = 6; i < 10; i++) step(1'b0, 1'b0, 1'b1, i * 4, 8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
